// File: rtl/io_periph_bank.sv
// io_periph_bank: memory-mapped I/O register bank on the processor's load/store path.
//
// Holds the LEDR, LEDG, LCD and NUM_HEX seven-segment output registers. All of them
// accept byte-enabled stores, and all of them can be read back combinationally.
// The raw switch inputs pass through a synchroniser and a debouncer. Each accepted
// switch change sets sticky event bits, and those bits, qualified by a mask, drive
// the interrupt.
//
// Ports:
//   clk_i, rst_ni   clock and synchronous active-low reset
//   addr_i          byte offset into the I/O region (bits [1:0] ignored)
//   wdata_i, be_i   store data and per-byte enables
//   st_en_i         store strobe (one store per cycle)
//   rdata_o         combinational read data for addr_i
//   err_o           unmapped address, or a store to the read-only SW register
//   io_sw_i         raw asynchronous switches
//   io_ledr_o, io_ledg_o, io_lcd_o, io_hex_o  board output registers
//   irq_o           OR of (switch events AND mask), taken from registers only
//
// Register map (byte offsets):
//   0x000 LEDR, 0x010 LEDG, 0x020+4k HEXk, 0x040 LCD,
//   0x080 SW (RO), 0x084 SW_EVT (W1C), 0x088 SW_MASK
module io_periph_bank #(
    parameter int NUM_HEX         = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [11:0]            addr_i,
    input  logic [31:0]            wdata_i,
    input  logic [3:0]             be_i,
    input  logic                   st_en_i,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    input  logic [31:0]            io_sw_i,
    output logic [31:0]            io_lcd_o,
    output logic [31:0]            io_ledr_o,
    output logic [31:0]            io_ledg_o,
    output logic [NUM_HEX*32-1:0]  io_hex_o,
    output logic                   irq_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Word addresses (byte offset >> 2)
    localparam logic [9:0] W_LEDR = 10'h000;
    localparam logic [9:0] W_LEDG = 10'h004;
    localparam logic [9:0] W_HEX0 = 10'h008;
    localparam logic [9:0] W_LCD  = 10'h010;
    localparam logic [9:0] W_SW   = 10'h020;
    localparam logic [9:0] W_EVT  = 10'h021;
    localparam logic [9:0] W_MASK = 10'h022;

    logic [9:0]       word_addr;
    logic             unused_addr_bits;
    logic             mapped, read_only;

    logic [31:0]      ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
    logic [31:0]      hex_q [NUM_HEX];
    logic [31:0]      hex_d [NUM_HEX];
    logic [31:0]      mask_q, mask_d, evt_q, evt_d;
    logic [31:0]      s1_q, s2_q, cand_q, cand_d, sw_db_q, sw_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      evt_set, evt_clr;

    assign word_addr        = addr_i[11:2];
    assign unused_addr_bits = ^addr_i[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode and combinational readback
    always_comb begin
        rdata_o   = '0;
        mapped    = 1'b0;
        read_only = 1'b0;
        case (word_addr)
            W_LEDR:  begin rdata_o = ledr_q;  mapped = 1'b1; end
            W_LEDG:  begin rdata_o = ledg_q;  mapped = 1'b1; end
            W_LCD:   begin rdata_o = lcd_q;   mapped = 1'b1; end
            W_SW:    begin rdata_o = sw_db_q; mapped = 1'b1; read_only = 1'b1; end
            W_EVT:   begin rdata_o = evt_q;   mapped = 1'b1; end
            W_MASK:  begin rdata_o = mask_q;  mapped = 1'b1; end
            default: ;
        endcase
        // HEX channels beyond NUM_HEX never match, so they fall out as unmapped
        for (int k = 0; k < NUM_HEX; k++) begin
            if (word_addr == W_HEX0 + 10'(k)) begin
                rdata_o = hex_q[k];
                mapped  = 1'b1;
            end
        end
    end

    assign err_o = !mapped || (read_only && st_en_i);

    // Register stores; an unmapped address matches nothing and is dropped
    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        lcd_d  = lcd_q;
        mask_d = mask_q;
        if (st_en_i && word_addr == W_LEDR) ledr_d = merge_bytes(ledr_q, wdata_i, be_i);
        if (st_en_i && word_addr == W_LEDG) ledg_d = merge_bytes(ledg_q, wdata_i, be_i);
        if (st_en_i && word_addr == W_LCD)  lcd_d  = merge_bytes(lcd_q,  wdata_i, be_i);
        if (st_en_i && word_addr == W_MASK) mask_d = merge_bytes(mask_q, wdata_i, be_i);
        for (int k = 0; k < NUM_HEX; k++) begin
            hex_d[k] = hex_q[k];
            if (st_en_i && word_addr == W_HEX0 + 10'(k)) begin
                hex_d[k] = merge_bytes(hex_q[k], wdata_i, be_i);
            end
        end
    end

    // Debounce: a candidate must stay put for DEBOUNCE_CYCLES cycles before
    // it replaces the accepted value; any change of s2 restarts the count.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sw_db_d = sw_db_q;
        evt_set = '0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cand_q != sw_db_q) begin
            if (cnt_q == CNT_LAST) begin
                sw_db_d = cand_q;
                evt_set = sw_db_q ^ cand_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Write-1-to-clear honours byte enables; a simultaneous set wins
    assign evt_clr = (st_en_i && word_addr == W_EVT) ? merge_bytes('0, wdata_i, be_i) : '0;
    assign evt_d   = (evt_q & ~evt_clr) | evt_set;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            lcd_q   <= '0;
            mask_q  <= '0;
            evt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            sw_db_q <= '0;
            for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= '0;
        end else begin
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            lcd_q   <= lcd_d;
            mask_q  <= mask_d;
            evt_q   <= evt_d;
            s1_q    <= io_sw_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_db_q <= sw_db_d;
            for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= hex_d[k];
        end
    end

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign io_hex_o[32*k +: 32] = hex_q[k];
    end

    assign io_ledr_o = ledr_q;
    assign io_ledg_o = ledg_q;
    assign io_lcd_o  = lcd_q;
    assign irq_o     = |(evt_q & mask_q);

endmodule

// File: tb/tb_io_periph_bank.sv
// Testbench for io_periph_bank with NUM_HEX=4 and DEBOUNCE_CYCLES=4.
//
// Stimulus is driven 1 time unit after each rising edge, and the expected values
// are pushed into exp_q at that same moment. A monitor on the falling edge pops
// each entry and compares it. The reference model treats the switch filter as a
// sliding window over the sampled switch history.
module tb_io_periph_bank;

    localparam int NH = 4;
    localparam int DB = 4;

    localparam int K_RD   = 0;
    localparam int K_ERR  = 1;
    localparam int K_IRQ  = 2;
    localparam int K_LEDR = 3;
    localparam int K_LEDG = 4;
    localparam int K_LCD  = 5;
    localparam int K_HEX  = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [11:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic             st_en;
    logic [31:0]      rdata;
    logic             err;
    logic [31:0]      sw;
    logic [31:0]      lcd, ledr, ledg;
    logic [NH*32-1:0] hex;
    logic             irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_periph_bank #(.NUM_HEX(NH), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .be_i      (be),
        .st_en_i   (st_en),
        .rdata_o   (rdata),
        .err_o     (err),
        .io_sw_i   (sw),
        .io_lcd_o  (lcd),
        .io_ledr_o (ledr),
        .io_ledg_o (ledg),
        .io_hex_o  (hex),
        .irq_o     (irq)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_ledr, m_ledg, m_lcd, m_db, m_evt, m_mask;
    logic [31:0] m_hex [NH];
    logic [31:0] m_hist[$];   // switch value seen at each edge since reset

    function automatic logic [31:0] with_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] b);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] set_m, clr_m, v;
        bit          stable;
        int          w;
        if (!rst_n) begin
            m_ledr = '0; m_ledg = '0; m_lcd = '0; m_db = '0; m_evt = '0; m_mask = '0;
            for (int k = 0; k < NH; k++) m_hex[k] = '0;
            m_hist.delete();
            for (int i = 0; i < DB + 2; i++) m_hist.push_back('0);
        end else begin
            // Accept v once the DB+1 samples ending two edges ago all equal v
            set_m = '0;
            if (m_hist.size() >= DB + 2) begin
                v = m_hist[m_hist.size() - 2];
                stable = 1;
                for (int i = 2; i <= DB + 2; i++) if (m_hist[m_hist.size() - i] != v) stable = 0;
                if (stable && v != m_db) begin
                    set_m = m_db ^ v;
                    m_db  = v;
                end
            end
            clr_m = '0;
            if (st_en) begin
                w = int'(addr[11:2]);
                if (w == 0) m_ledr = with_bytes(m_ledr, wdata, be);
                else if (w == 4) m_ledg = with_bytes(m_ledg, wdata, be);
                else if (w >= 8 && w < 8 + NH) m_hex[w-8] = with_bytes(m_hex[w-8], wdata, be);
                else if (w == 16) m_lcd = with_bytes(m_lcd, wdata, be);
                else if (w == 33) clr_m = with_bytes('0, wdata, be);
                else if (w == 34) m_mask = with_bytes(m_mask, wdata, be);
            end
            m_evt = (m_evt & ~clr_m) | set_m;
            m_hist.push_back(sw);
            if (m_hist.size() > 32) void'(m_hist.pop_front());
        end
    end

    // {mapped, data}
    function automatic logic [32:0] m_read(input logic [11:0] a);
        int w;
        w = int'(a[11:2]);
        if (w == 0) return {1'b1, m_ledr};
        if (w == 4) return {1'b1, m_ledg};
        if (w >= 8 && w < 8 + NH) return {1'b1, m_hex[w-8]};
        if (w == 16) return {1'b1, m_lcd};
        if (w == 32) return {1'b1, m_db};
        if (w == 33) return {1'b1, m_evt};
        if (w == 34) return {1'b1, m_mask};
        return {1'b0, 32'h0};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t exp_q[$];

    task automatic push(input int kind, input int idx, input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = kind; c.idx = idx; c.exp = e; c.name = nm;
        exp_q.push_back(c);
    endtask

    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            case (c.kind)
                K_RD:    act = rdata;
                K_ERR:   act = {31'b0, err};
                K_IRQ:   act = {31'b0, irq};
                K_LEDR:  act = ledr;
                K_LEDG:  act = ledg;
                K_LCD:   act = lcd;
                K_HEX:   act = hex[32*c.idx +: 32];
                default: act = '0;
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s[%0d] got %h exp %h at %0t", c.name, c.idx, act, c.exp, $time);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic r, input logic s, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        @(posedge clk);
        #1;
        rst_n = r; st_en = s; addr = a; wdata = d; be = b;
    endtask

    task automatic push_model();
        logic [32:0] rd;
        rd = m_read(addr);
        push(K_RD, 0, rd[31:0], "rdata");
        push(K_ERR, 0, {31'b0, !rd[32] || (st_en && addr[11:2] == 10'h020)}, "err");
        push(K_IRQ, 0, {31'b0, |(m_evt & m_mask)}, "irq");
        push(K_LEDR, 0, m_ledr, "ledr");
        push(K_LEDG, 0, m_ledg, "ledg");
        push(K_LCD, 0, m_lcd, "lcd");
        for (int k = 0; k < NH; k++) push(K_HEX, k, m_hex[k], "hex");
    endtask

    logic [11:0] map_list [10] = '{12'h000, 12'h010, 12'h020, 12'h024, 12'h028,
                                   12'h02C, 12'h040, 12'h080, 12'h084, 12'h088};
    logic [11:0] rnd_list [14] = '{12'h000, 12'h010, 12'h020, 12'h024, 12'h028, 12'h02C,
                                   12'h030, 12'h03C, 12'h040, 12'h080, 12'h084, 12'h088,
                                   12'h08C, 12'h100};
    logic [31:0] sw_list [5] = '{32'h0, 32'h1, 32'h5, 32'h4, 32'h8000_0001};

    initial begin
        int hold;
        rst_n = 1'b0; st_en = 1'b1; wdata = 32'hFFFF_FFFF; be = 4'hF; addr = '0; sw = '0;

        // Reset held for two edges while a store is presented
        @(posedge clk);
        @(posedge clk);
        #1;
        push(K_LEDR, 0, 0, "rst_ledr");
        push(K_LEDG, 0, 0, "rst_ledg");
        push(K_LCD, 0, 0, "rst_lcd");
        for (int k = 0; k < NH; k++) push(K_HEX, k, 0, "rst_hex");
        push(K_IRQ, 0, 0, "rst_irq");
        push(K_RD, 0, 0, "rst_rd_ledr");
        foreach (map_list[i]) begin
            cyc(1, 0, map_list[i], 0, 0);
            push(K_RD, 0, 0, "rst_read");
            push(K_ERR, 0, 0, "mapped_err");
        end

        // Byte-enable stores and same-cycle readback of the old value
        cyc(1, 1, 12'h020, 32'h1234_5678, 4'hF);
        push(K_RD, 0, 0, "same_cycle_old");
        cyc(1, 1, 12'h020, 32'hAABB_CCDD, 4'h5);
        push(K_HEX, 0, 32'h1234_5678, "hex0_full");
        push(K_RD, 0, 32'h1234_5678, "rd_before_be");
        cyc(1, 0, 12'h023, 0, 0);
        push(K_HEX, 0, 32'h12BB_56DD, "hex0_be");
        push(K_RD, 0, 32'h12BB_56DD, "rd_hex0_lowbits");
        for (int k = 1; k < NH; k++) push(K_HEX, k, 0, "hex_untouched");

        // Unmapped and read-only stores
        cyc(1, 1, 12'h030, 32'hDEAD_BEEF, 4'hF);
        push(K_ERR, 0, 1, "err_unmapped");
        push(K_RD, 0, 0, "rd_unmapped");
        cyc(1, 1, 12'h080, 32'hFFFF_FFFF, 4'hF);
        push(K_ERR, 0, 1, "err_ro");
        push(K_HEX, 0, 32'h12BB_56DD, "hex0_after_unmapped");
        for (int k = 1; k < NH; k++) push(K_HEX, k, 0, "hex_after_unmapped");
        push(K_LEDR, 0, 0, "ledr_after_unmapped");
        push(K_LCD, 0, 0, "lcd_after_unmapped");
        cyc(1, 0, 12'h080, 0, 0);
        push(K_RD, 0, 0, "sw_after_ro_store");
        push(K_ERR, 0, 0, "err_ro_load");

        // Glitch: three samples of 0x1, then back to 0
        cyc(1, 0, 12'h080, 0, 0);
        sw = 32'h1;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, (i % 2 == 1) ? 12'h084 : 12'h080, 0, 0);
            if (i == 2) sw = 32'h0;
            push(K_RD, 0, 0, "glitch_sw_evt");
            push(K_IRQ, 0, 0, "glitch_irq");
        end

        // Debounce accept: new value seen at edge 1, accepted at edge 7
        cyc(1, 0, 12'h080, 0, 0);
        sw = 32'h5;
        for (int e = 1; e <= 6; e++) begin
            cyc(1, 0, 12'h080, 0, 0);
            push(K_RD, 0, 0, "sw_before_edge7");
        end
        cyc(1, 0, 12'h080, 0, 0);
        push(K_RD, 0, 32'h5, "sw_at_edge7");
        cyc(1, 0, 12'h084, 0, 0);
        push(K_RD, 0, 32'h5, "evt_after_accept");
        push(K_IRQ, 0, 0, "irq_masked_off");

        // Mask, interrupt, W1C
        cyc(1, 1, 12'h088, 32'h1, 4'h1);
        push(K_IRQ, 0, 0, "irq_before_mask");
        cyc(1, 0, 12'h088, 0, 0);
        push(K_RD, 0, 32'h1, "mask_rd");
        push(K_IRQ, 0, 1, "irq_set");
        cyc(1, 1, 12'h084, 32'h1, 4'hF);
        push(K_IRQ, 0, 1, "irq_before_clr");
        cyc(1, 0, 12'h084, 0, 0);
        push(K_IRQ, 0, 0, "irq_cleared");
        push(K_RD, 0, 32'h4, "evt_after_clr");
        cyc(1, 1, 12'h084, 32'h4, 4'hE);
        cyc(1, 0, 12'h084, 0, 0);
        push(K_RD, 0, 32'h4, "w1c_byte_disabled");

        // Collision: W1C of bit0 lands on the edge that accepts a bit0 change
        sw = 32'h4;
        for (int e = 1; e <= 5; e++) cyc(1, 0, 12'h084, 0, 0);
        cyc(1, 1, 12'h084, 32'h1, 4'hF);
        push(K_RD, 0, 32'h4, "evt_pre_collision");
        cyc(1, 0, 12'h084, 0, 0);
        push(K_RD, 0, 32'h5, "evt_collision");
        push(K_IRQ, 0, 1, "irq_collision");
        cyc(1, 0, 12'h080, 0, 0);
        push(K_RD, 0, 32'h4, "sw_after_collision");

        // Randomised traffic against the model
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            logic [11:0] a;
            if ($urandom_range(0, 7) == 0) a = 12'($urandom());
            else a = rnd_list[$urandom_range(0, 13)] | 12'($urandom_range(0, 3));
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), a,
                $urandom(), 4'($urandom_range(0, 15)));
            if (hold == 0) begin
                sw   = ($urandom_range(0, 5) == 5) ? $urandom() : sw_list[$urandom_range(0, 4)];
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            push_model();
        end

        cyc(1, 0, 12'h000, 0, 0);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
